alu_issue_ctrl: RTL and testbench

- Initiator side of the 32-bit ALU interface: accepts one decoded-instruction request at a time and produces the ALU's control code and operands.
- Maps the MIPS opcode/funct to the 4-bit ALUControl encoding and forms operands A/B (register data, shamt, sign- or zero-extended immediate).
- Holds ALUControl/A/B stable, samples ALUResult/Zero after a programmable settle time, and returns result plus branch decision over a valid/ready handshake.
- Sits between the ID/EX control path and the combinational ALU.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/alu_issue_ctrl_if.sv | 29 ++
 rtl/alu_decode.sv | 175 +++++++++++++++++
 rtl/alu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller:
//   - 4-bit ALUControl codes understood by the downstream combinational ALU
//   - MIPS opcode / funct field values that the decoder recognises
//   - issue FSM state type
//   - legal range for the ALUResult settle delay and its check function
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALUControl codes
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd11;   // B[5]=1 turns this into rotr
    localparam logic [3:0] ALU_XOR  = 4'd12;
    localparam logic [3:0] ALU_SLTU = 4'd13;
    localparam logic [3:0] ALU_SRA  = 4'd15;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct values
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Settle delay range (fits the 4-bit down-counter)
    localparam int unsigned CAPTURE_DELAY_MIN = 32'd1;
    localparam int unsigned CAPTURE_DELAY_MAX = 32'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } issue_state_t;

    function automatic logic capture_delay_ok(input int unsigned delay);
        return (delay >= CAPTURE_DELAY_MIN) && (delay <= CAPTURE_DELAY_MAX);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Request / response handshake between the ID/EX control path (master) and
// the ALU issue controller (slave).
//   Request : ReqValid, ReqReady, Instr, RsData, RtData
//   Response: RespValid, RespReady, Result, BranchTaken, Illegal
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;
    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] Instr;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] Result;
    logic        BranchTaken;
    logic        Illegal;

    modport master (
        output ReqValid, Instr, RsData, RtData, RespReady,
        input  ReqReady, RespValid, Result, BranchTaken, Illegal
    );

    modport slave (
        input  ReqValid, Instr, RsData, RtData, RespReady,
        output ReqReady, RespValid, Result, BranchTaken, Illegal
    );
endinterface

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Purely combinational MIPS decode into ALU control code and operands.
// Ports:
//   Instr, RsData, RtData -> instruction word and register operands
//   ALUControl, A, B      -> ALU code and operands for this instruction
//   is_branch, is_bne     -> beq/bne classification for the branch decision
//   illegal               -> opcode/funct not handled by this ALU path
// ---------------------------------------------------------------------------
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] Instr,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic [3:0]  ALUControl,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        is_branch,
    output logic        is_bne,
    output logic        illegal
);

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;
    logic [31:0] simm_s;
    logic [31:0] zimm_s;
    logic        unused_fields_s;

    assign opcode_s = Instr[31:26];
    assign funct_s  = Instr[5:0];
    assign shamt_s  = Instr[10:6];
    assign imm_s    = Instr[15:0];
    assign simm_s   = {{16{imm_s[15]}}, imm_s};
    assign zimm_s   = {16'd0, imm_s};

    // Register-number fields are resolved upstream; only folded here.
    assign unused_fields_s = ^{Instr[25:22], Instr[20:16]};

    // Opcode/funct to ALU code and operand selection
    always_comb begin
        ALUControl = ALU_AND;
        A          = 32'd0;
        B          = 32'd0;
        is_branch  = 1'b0;
        is_bne     = 1'b0;
        illegal    = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_SLL: begin
                        ALUControl = ALU_SLL;
                        A          = RtData;
                        B          = {27'd0, shamt_s};
                    end
                    FN_SRL: begin
                        // Instr[21] lands on B[5], which the ALU reads as rotate.
                        ALUControl = ALU_SRL;
                        A          = RtData;
                        B          = {26'd0, Instr[21], shamt_s};
                    end
                    FN_SRA: begin
                        ALUControl = ALU_SRA;
                        A          = RtData;
                        B          = {27'd0, shamt_s};
                    end
                    FN_SLLV: begin
                        ALUControl = ALU_SLL;
                        A          = RtData;
                        B          = RsData;
                    end
                    FN_ADD, FN_ADDU: begin
                        ALUControl = ALU_ADD;
                        A          = RsData;
                        B          = RtData;
                    end
                    FN_SUB, FN_SUBU: begin
                        ALUControl = ALU_SUB;
                        A          = RsData;
                        B          = RtData;
                    end
                    FN_AND: begin
                        ALUControl = ALU_AND;
                        A          = RsData;
                        B          = RtData;
                    end
                    FN_OR: begin
                        ALUControl = ALU_OR;
                        A          = RsData;
                        B          = RtData;
                    end
                    FN_XOR: begin
                        ALUControl = ALU_XOR;
                        A          = RsData;
                        B          = RtData;
                    end
                    FN_NOR: begin
                        ALUControl = ALU_NOR;
                        A          = RsData;
                        B          = RtData;
                    end
                    FN_SLT: begin
                        ALUControl = ALU_SLT;
                        A          = RsData;
                        B          = RtData;
                    end
                    FN_SLTU: begin
                        ALUControl = ALU_SLTU;
                        A          = RsData;
                        B          = RtData;
                    end
                    default: begin
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ALUControl = ALU_ADD;
                A          = RsData;
                B          = simm_s;
            end
            OP_SLTI: begin
                ALUControl = ALU_SLT;
                A          = RsData;
                B          = simm_s;
            end
            OP_SLTIU: begin
                // Unsigned compare against the sign-extended immediate.
                ALUControl = ALU_SLTU;
                A          = RsData;
                B          = simm_s;
            end
            OP_ANDI: begin
                ALUControl = ALU_AND;
                A          = RsData;
                B          = zimm_s;
            end
            OP_ORI: begin
                ALUControl = ALU_OR;
                A          = RsData;
                B          = zimm_s;
            end
            OP_XORI: begin
                ALUControl = ALU_XOR;
                A          = RsData;
                B          = zimm_s;
            end
            OP_LUI: begin
                // lui is carried out by the ALU as imm << 16.
                ALUControl = ALU_SLL;
                A          = zimm_s;
                B          = 32'd16;
            end
            OP_BEQ: begin
                ALUControl = ALU_SUB;
                A          = RsData;
                B          = RtData;
                is_branch  = 1'b1;
            end
            OP_BNE: begin
                ALUControl = ALU_SUB;
                A          = RsData;
                B          = RtData;
                is_branch  = 1'b1;
                is_bne     = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the 32-bit ALU interface. Accepts one decoded request,
// drives ALUControl/A/B from registers, waits CAPTURE_DELAY cycles for the
// combinational ALU to settle, captures ALUResult/Zero and returns the result
// and branch decision over a valid/ready response.
// Ports:
//   Clk, Rst       -> clock, synchronous active-high reset
//   bus (slave)    -> request/response handshake (see alu_issue_ctrl_if)
//   ALUControl,A,B -> registered ALU inputs, change only on a legal accept
//   ALUResult,Zero -> combinational ALU outputs, sampled at end of settle
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned CAPTURE_DELAY = 32'd1
)
(
    input  logic              Clk,
    input  logic              Rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [3:0]        ALUControl,
    output logic [31:0]       A,
    output logic [31:0]       B,
    input  logic [31:0]       ALUResult,
    input  logic              Zero
);

    localparam logic [3:0] DELAY_CNT = 4'(CAPTURE_DELAY);

    if (!capture_delay_ok(CAPTURE_DELAY)) begin : g_bad_capture_delay
        $error("alu_issue_ctrl: CAPTURE_DELAY must be within 1..15");
    end

    logic [3:0]   dec_control_s;
    logic [31:0]  dec_a_s;
    logic [31:0]  dec_b_s;
    logic         dec_is_branch_s;
    logic         dec_is_bne_s;
    logic         dec_illegal_s;

    issue_state_t state_r;
    logic [3:0]   count_r;
    logic [3:0]   alu_control_r;
    logic [31:0]  a_r;
    logic [31:0]  b_r;
    logic         is_branch_r;
    logic         is_bne_r;
    logic [31:0]  result_r;
    logic         branch_taken_r;
    logic         illegal_r;
    logic         resp_valid_r;
    logic         req_ready_r;

    alu_decode u_decode (
        .Instr      (bus.Instr),
        .RsData     (bus.RsData),
        .RtData     (bus.RtData),
        .ALUControl (dec_control_s),
        .A          (dec_a_s),
        .B          (dec_b_s),
        .is_branch  (dec_is_branch_s),
        .is_bne     (dec_is_bne_s),
        .illegal    (dec_illegal_s)
    );

    // Issue FSM: accept, settle count, capture, hold response until taken
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r        <= ST_IDLE;
            count_r        <= 4'd0;
            alu_control_r  <= 4'd0;
            a_r            <= 32'd0;
            b_r            <= 32'd0;
            is_branch_r    <= 1'b0;
            is_bne_r       <= 1'b0;
            result_r       <= 32'd0;
            branch_taken_r <= 1'b0;
            illegal_r      <= 1'b0;
            resp_valid_r   <= 1'b0;
            req_ready_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready_r <= 1'b1;
                    if (bus.ReqValid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        if (dec_illegal_s) begin
                            // ALU inputs stay untouched so nothing downstream toggles.
                            illegal_r      <= 1'b1;
                            result_r       <= 32'd0;
                            branch_taken_r <= 1'b0;
                            resp_valid_r   <= 1'b1;
                            state_r        <= ST_RESP;
                        end else begin
                            alu_control_r <= dec_control_s;
                            a_r           <= dec_a_s;
                            b_r           <= dec_b_s;
                            is_branch_r   <= dec_is_branch_s;
                            is_bne_r      <= dec_is_bne_s;
                            illegal_r     <= 1'b0;
                            count_r       <= DELAY_CNT;
                            state_r       <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    count_r <= count_r - 4'd1;
                    if (count_r == 4'd1) begin
                        result_r       <= ALUResult;
                        // beq takes on Zero, bne on !Zero; others never take.
                        branch_taken_r <= is_branch_r & (Zero ^ is_bne_r);
                        resp_valid_r   <= 1'b1;
                        state_r        <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (bus.RespReady) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign ALUControl      = alu_control_r;
    assign A               = a_r;
    assign B               = b_r;
    assign bus.ReqReady    = req_ready_r;
    assign bus.RespValid   = resp_valid_r;
    assign bus.Result      = result_r;
    assign bus.BranchTaken = branch_taken_r;
    assign bus.Illegal     = illegal_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Two controller instances (CAPTURE_DELAY 1 and 4) share the stimulus; `sel`
// picks which one sees requests and which one is observed. Each drives a
// golden ALU. Expected values come from MIPS instruction semantics.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        sel;
    logic        req_valid;
    logic        resp_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_ctl [2];
    logic [31:0] exp_a   [2];
    logic [31:0] exp_b   [2];

    always #5 Clk = ~Clk;

    alu_issue_ctrl_if bus1 ();
    alu_issue_ctrl_if bus4 ();

    logic [3:0]  ctl1, ctl4;
    logic [31:0] a1, b1, r1, a4, b4, r4;
    logic        z1, z4;

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] dbl;
        dbl = {a, a} >> b[4:0];
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return ~(a | b);
            4'd8:    return a << b[4:0];
            4'd11:   return b[5] ? dbl[31:0] : (a >> b[4:0]);
            4'd12:   return a ^ b;
            4'd13:   return (a < b) ? 32'd1 : 32'd0;
            4'd15:   return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign r1 = alu_model(ctl1, a1, b1);
    assign z1 = (r1 == 32'd0);
    assign r4 = alu_model(ctl4, a4, b4);
    assign z4 = (r4 == 32'd0);

    assign bus1.ReqValid  = req_valid & ~sel;
    assign bus1.RespReady = resp_ready & ~sel;
    assign bus1.Instr     = instr;
    assign bus1.RsData    = rs_data;
    assign bus1.RtData    = rt_data;
    assign bus4.ReqValid  = req_valid & sel;
    assign bus4.RespReady = resp_ready & sel;
    assign bus4.Instr     = instr;
    assign bus4.RsData    = rs_data;
    assign bus4.RtData    = rt_data;

    alu_issue_ctrl #(.CAPTURE_DELAY(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .bus(bus1.slave),
        .ALUControl(ctl1), .A(a1), .B(b1), .ALUResult(r1), .Zero(z1)
    );

    alu_issue_ctrl #(.CAPTURE_DELAY(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .bus(bus4.slave),
        .ALUControl(ctl4), .A(a4), .B(b4), .ALUResult(r4), .Zero(z4)
    );

    logic        o_ready, o_rv, o_taken, o_ill;
    logic [3:0]  o_ctl;
    logic [31:0] o_a, o_b, o_res;
    assign o_ready = sel ? bus4.ReqReady    : bus1.ReqReady;
    assign o_rv    = sel ? bus4.RespValid   : bus1.RespValid;
    assign o_taken = sel ? bus4.BranchTaken : bus1.BranchTaken;
    assign o_ill   = sel ? bus4.Illegal     : bus1.Illegal;
    assign o_res   = sel ? bus4.Result      : bus1.Result;
    assign o_ctl   = sel ? ctl4 : ctl1;
    assign o_a     = sel ? a4 : a1;
    assign o_b     = sel ? b4 : b1;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Instruction-level reference: what the ALU must be asked and what it must return.
    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                              output logic legal, output logic [3:0] ctl, output logic [31:0] ea,
                              output logic [31:0] eb, output logic [31:0] res, output logic taken);
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [31:0] simm, zimm;
        logic [63:0] dbl;
        op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'd0, ins[15:0]};
        legal = 1'b1; taken = 1'b0; ctl = 4'd0; ea = rs; eb = rt; res = 32'd0;
        case (op)
            6'h00: case (fn)
                6'h00: begin ctl = 4'd8;  ea = rt; eb = {27'd0, sh}; res = rt << sh; end
                6'h02: begin
                    ctl = 4'd11; ea = rt; eb = {26'd0, ins[21], sh};
                    dbl = {rt, rt} >> sh;
                    res = ins[21] ? dbl[31:0] : (rt >> sh);
                end
                6'h03: begin ctl = 4'd15; ea = rt; eb = {27'd0, sh}; res = $signed(rt) >>> sh; end
                6'h04: begin ctl = 4'd8;  ea = rt; eb = rs; res = rt << rs[4:0]; end
                6'h20, 6'h21: begin ctl = 4'd2; res = rs + rt; end
                6'h22, 6'h23: begin ctl = 4'd3; res = rs - rt; end
                6'h24: begin ctl = 4'd0;  res = rs & rt; end
                6'h25: begin ctl = 4'd1;  res = rs | rt; end
                6'h26: begin ctl = 4'd12; res = rs ^ rt; end
                6'h27: begin ctl = 4'd5;  res = ~(rs | rt); end
                6'h2A: begin ctl = 4'd4;  res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
                6'h2B: begin ctl = 4'd13; res = (rs < rt) ? 32'd1 : 32'd0; end
                default: legal = 1'b0;
            endcase
            6'h08, 6'h09: begin ctl = 4'd2;  eb = simm; res = rs + simm; end
            6'h0A: begin ctl = 4'd4;  eb = simm; res = ($signed(rs) < $signed(simm)) ? 32'd1 : 32'd0; end
            6'h0B: begin ctl = 4'd13; eb = simm; res = (rs < simm) ? 32'd1 : 32'd0; end
            6'h0C: begin ctl = 4'd0;  eb = zimm; res = rs & zimm; end
            6'h0D: begin ctl = 4'd1;  eb = zimm; res = rs | zimm; end
            6'h0E: begin ctl = 4'd12; eb = zimm; res = rs ^ zimm; end
            6'h0F: begin ctl = 4'd8;  ea = zimm; eb = 32'd16; res = {ins[15:0], 16'd0}; end
            6'h04: begin ctl = 4'd3; res = rs - rt; taken = (rs == rt); end
            6'h05: begin ctl = 4'd3; res = rs - rt; taken = (rs != rt); end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            res = 32'd0;
            taken = 1'b0;
        end
    endtask

    // One request through the currently selected instance; hold = cycles of response backpressure.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                          input int hold, input string tag);
        logic        legal, taken;
        logic [3:0]  ctl;
        logic [31:0] ea, eb, eres;
        int          s, cd, n;
        s  = sel ? 1 : 0;
        cd = sel ? 4 : 1;
        ref_decode(ins, rs, rt, legal, ctl, ea, eb, eres, taken);
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " ready_before"}, {31'd0, o_ready}, 32'd1);
        instr = ins; rs_data = rs; rt_data = rt; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        // Scramble inputs: operands must have been registered at accept.
        instr = $urandom; rs_data = $urandom; rt_data = $urandom;
        chk({tag, " ready_after_accept"}, {31'd0, o_ready}, 32'd0);
        if (legal) begin
            exp_ctl[s] = ctl; exp_a[s] = ea; exp_b[s] = eb;
            chk({tag, " ctl"}, {28'd0, o_ctl}, {28'd0, ctl});
            chk({tag, " a"}, o_a, ea);
            chk({tag, " b"}, o_b, eb);
            chk({tag, " rv_early"}, {31'd0, o_rv}, 32'd0);
            for (int k = 1; k < cd; k++) begin
                tick();
                chk({tag, " rv_wait"}, {31'd0, o_rv}, 32'd0);
                chk({tag, " b_stable"}, o_b, eb);
            end
            tick();
        end
        chk({tag, " rv"}, {31'd0, o_rv}, 32'd1);
        chk({tag, " result"}, o_res, eres);
        chk({tag, " taken"}, {31'd0, o_taken}, {31'd0, taken});
        chk({tag, " illegal"}, {31'd0, o_ill}, {31'd0, ~legal});
        chk({tag, " ctl_hold"}, {28'd0, o_ctl}, {28'd0, exp_ctl[s]});
        chk({tag, " a_hold"}, o_a, exp_a[s]);
        chk({tag, " b_hold"}, o_b, exp_b[s]);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; instr = 32'h0022_1820;
            tick();
            chk({tag, " bp_rv"}, {31'd0, o_rv}, 32'd1);
            chk({tag, " bp_ready"}, {31'd0, o_ready}, 32'd0);
            chk({tag, " bp_result"}, o_res, eres);
            chk({tag, " bp_ctl"}, {28'd0, o_ctl}, {28'd0, exp_ctl[s]});
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, " rv_cleared"}, {31'd0, o_rv}, 32'd0);
        chk({tag, " ready_back"}, {31'd0, o_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int p;
        w = $urandom;
        p = $urandom_range(0, 27);
        case (p)
            0:  w[31:26] = 6'h00;
            1:  begin w[31:26] = 6'h00; w[5:0] = 6'h02; end
            2:  begin w[31:26] = 6'h00; w[5:0] = 6'h03; end
            3:  begin w[31:26] = 6'h00; w[5:0] = 6'h04; end
            4:  begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            5:  begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
            6:  begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
            7:  begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
            8:  begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
            9:  begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            10: begin w[31:26] = 6'h00; w[5:0] = 6'h26; end
            11: begin w[31:26] = 6'h00; w[5:0] = 6'h27; end
            12: begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
            13: begin w[31:26] = 6'h00; w[5:0] = 6'h2B; end
            14: w[31:26] = 6'h04;
            15: w[31:26] = 6'h05;
            16: w[31:26] = 6'h08;
            17: w[31:26] = 6'h09;
            18: w[31:26] = 6'h0A;
            19: w[31:26] = 6'h0B;
            20: w[31:26] = 6'h0C;
            21: w[31:26] = 6'h0D;
            22: w[31:26] = 6'h0E;
            23: w[31:26] = 6'h0F;
            24: begin w[31:26] = 6'h00; w[5:0] = 6'h01; end
            25: begin w[31:26] = 6'h00; w[5:0] = 6'h3F; end
            26: w[31:26] = 6'h02;
            default: w[31:26] = 6'h3F;
        endcase
        if (p == 0) w[5:0] = 6'h00;
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rs, rt;
        Rst = 1'b1; sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        for (int i = 0; i < 2; i++) begin
            exp_ctl[i] = 4'd0; exp_a[i] = 32'd0; exp_b[i] = 32'd0;
        end
        tick(); tick(); tick();
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            chk("rst ctl", {28'd0, o_ctl}, 32'd0);
            chk("rst a", o_a, 32'd0);
            chk("rst b", o_b, 32'd0);
            chk("rst result", o_res, 32'd0);
            chk("rst rv", {31'd0, o_rv}, 32'd0);
            chk("rst ready", {31'd0, o_ready}, 32'd0);
            chk("rst taken", {31'd0, o_taken}, 32'd0);
            chk("rst illegal", {31'd0, o_ill}, 32'd0);
        end
        sel = 1'b0;
        Rst = 1'b0;
        tick();

        // Directed cases on CAPTURE_DELAY=1
        run_op(32'h0022_1820, 32'd5, 32'd7, 0, "add");
        chk("add result const", o_res, 32'd12);
        run_op(32'h2021_FFFF, 32'd0, 32'd0, 0, "addi_sext");
        chk("addi result const", o_res, 32'hFFFF_FFFF);
        run_op(32'h3C01_1234, 32'd0, 32'd0, 0, "lui");
        chk("lui result const", o_res, 32'h1234_0000);
        run_op(32'h1022_0003, 32'd9, 32'd9, 0, "beq_taken");
        run_op(32'h1022_0003, 32'd9, 32'd8, 0, "beq_not");
        run_op(32'h1422_0003, 32'd9, 32'd8, 0, "bne_taken");
        run_op(32'hFC00_0000, 32'd1, 32'd2, 0, "illegal");
        run_op(32'h0022_1822, 32'd3, 32'd10, 3, "sub_backpressure");
        run_op(32'h0002_1FC2 | 32'h0020_0000, 32'd0, 32'h8000_0001, 0, "rotr");

        // Reset mid-WAIT on CAPTURE_DELAY=4 (count 4 -> 3 -> 2)
        sel = 1'b1;
        run_op(32'h0022_1825, 32'h0F0F_0000, 32'h0000_F0F0, 1, "or_d4");
        instr = 32'h0022_1820; rs_data = 32'd40; rt_data = 32'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("rstwait rv", {31'd0, o_rv}, 32'd0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rstwait ctl", {28'd0, o_ctl}, 32'd0);
        chk("rstwait a", o_a, 32'd0);
        chk("rstwait b", o_b, 32'd0);
        chk("rstwait result", o_res, 32'd0);
        chk("rstwait rv0", {31'd0, o_rv}, 32'd0);
        chk("rstwait ready", {31'd0, o_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            exp_ctl[i] = 4'd0; exp_a[i] = 32'd0; exp_b[i] = 32'd0;
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstwait no_resp", {31'd0, o_rv}, 32'd0);
        end
        run_op(32'h0022_1820, 32'd5, 32'd7, 0, "add_after_rst");

        // Randomized operations on both instances
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int i = 0; i < 30; i++) begin
                rs = $urandom;
                rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
                run_op(rand_instr(), rs, rt, $urandom_range(0, 2), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
